// File: rtl/request_shaper.sv
// Request shaper: per-device job front-end for a fixed-priority grant arbiter.
// Holds each request until its job's beats complete, with tenure limit and cooldown.
module request_shaper #(
  parameter int N_DEV      = 3,
  parameter int LEN_W      = 8,
  parameter int MAX_TENURE = 64,
  parameter int COOLDOWN   = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_DEV-1:0]       job_valid,
  input  logic [N_DEV*LEN_W-1:0] job_len,
  output logic [N_DEV-1:0]       job_ready,
  output logic [N_DEV-1:0]       r,
  input  logic [N_DEV-1:0]       g,
  output logic [N_DEV-1:0]       beat,
  output logic [N_DEV-1:0]       job_done,
  output logic                   grant_err
);
  localparam int TEN_W = $clog2(MAX_TENURE + 1);
  localparam int CD_W  = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_OWN  = 2'd2;
  localparam logic [1:0] S_COOL = 2'd3;

  localparam logic [LEN_W-1:0] LEN_ZERO = LEN_W'(0);
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
  localparam logic [TEN_W-1:0] TEN_ONE  = TEN_W'(1);
  localparam logic [TEN_W-1:0] TEN_MAX  = TEN_W'(MAX_TENURE);
  localparam logic [CD_W-1:0]  CD_ZERO  = CD_W'(0);
  localparam logic [CD_W-1:0]  CD_ONE   = CD_W'(1);
  localparam logic [CD_W-1:0]  CD_INIT  = CD_W'(COOLDOWN - 1);

  logic [N_DEV-1:0][1:0]       r_state;
  logic [N_DEV-1:0][1:0]       w_state_nxt;
  logic [N_DEV-1:0][LEN_W-1:0] r_rem;
  logic [N_DEV-1:0][LEN_W-1:0] w_rem_nxt;
  logic [N_DEV-1:0][TEN_W-1:0] r_ten;
  logic [N_DEV-1:0][TEN_W-1:0] w_ten_nxt;
  logic [N_DEV-1:0][CD_W-1:0]  r_cd;
  logic [N_DEV-1:0][CD_W-1:0]  w_cd_nxt;
  logic [N_DEV-1:0]            r_req;
  logic [N_DEV-1:0]            w_req_nxt;
  logic [N_DEV-1:0]            r_done;
  logic [N_DEV-1:0]            w_done_nxt;
  logic [N_DEV-1:0]            w_in_cool;
  logic                        r_gerr;
  logic                        w_gerr_hit;

  function automatic logic multi_hot(input logic [N_DEV-1:0] v);
    return (v & (v - N_DEV'(1))) != {N_DEV{1'b0}};
  endfunction

  // State and counter registers, request/done/error output flops
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= '0;
      r_rem   <= '0;
      r_ten   <= '0;
      r_cd    <= '0;
      r_req   <= '0;
      r_done  <= '0;
      r_gerr  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rem   <= w_rem_nxt;
      r_ten   <= w_ten_nxt;
      r_cd    <= w_cd_nxt;
      r_req   <= w_req_nxt;
      r_done  <= w_done_nxt;
      r_gerr  <= r_gerr | w_gerr_hit;
    end
  end

  // Per-channel next-state; r is registered from next state so it tracks the FSM without lag
  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_rem;
    w_ten_nxt   = r_ten;
    w_cd_nxt    = r_cd;
    w_done_nxt  = '0;
    w_req_nxt   = '0;
    for (int i = 0; i < N_DEV; i++) begin
      case (r_state[i])
        S_IDLE: begin
          if (job_valid[i]) begin
            if (job_len[i*LEN_W +: LEN_W] != LEN_ZERO) begin
              w_state_nxt[i] = S_REQ;
              w_rem_nxt[i]   = job_len[i*LEN_W +: LEN_W];
              w_ten_nxt[i]   = TEN_W'(0);
            end else begin
              w_done_nxt[i]  = 1'b1;
            end
          end else begin
            w_state_nxt[i] = S_IDLE;
          end
        end
        S_REQ, S_OWN: begin
          if (beat[i]) begin
            w_rem_nxt[i] = r_rem[i] - LEN_ONE;
            w_ten_nxt[i] = (r_state[i] == S_REQ) ? TEN_ONE : (r_ten[i] + TEN_ONE);
            // Completion wins over preemption when both land on the same beat
            if (r_rem[i] == LEN_ONE) begin
              w_state_nxt[i] = S_COOL;
              w_cd_nxt[i]    = CD_INIT;
              w_done_nxt[i]  = 1'b1;
            end else if (w_ten_nxt[i] == TEN_MAX) begin
              w_state_nxt[i] = S_COOL;
              w_cd_nxt[i]    = CD_INIT;
            end else begin
              w_state_nxt[i] = S_OWN;
            end
          end else begin
            w_state_nxt[i] = r_state[i];
          end
        end
        S_COOL: begin
          if (r_cd[i] == CD_ZERO) begin
            w_state_nxt[i] = (r_rem[i] != LEN_ZERO) ? S_REQ : S_IDLE;
          end else begin
            w_cd_nxt[i] = r_cd[i] - CD_ONE;
          end
        end
        default: begin
          w_state_nxt[i] = S_IDLE;
        end
      endcase
      w_req_nxt[i] = (w_state_nxt[i] == S_REQ) || (w_state_nxt[i] == S_OWN);
    end
    w_gerr_hit = multi_hot(g) || ((g & ~r_req & ~w_in_cool) != {N_DEV{1'b0}});
  end

  // Output decode
  always_comb begin
    job_ready = '0;
    w_in_cool = '0;
    for (int i = 0; i < N_DEV; i++) begin
      job_ready[i] = (r_state[i] == S_IDLE);
      w_in_cool[i] = (r_state[i] == S_COOL);
    end
    beat      = r_req & g;
    r         = r_req;
    job_done  = r_done;
    grant_err = r_gerr;
  end

endmodule
